// File: rtl/dmem_pkg.sv
// Shared address map, read defaults and region decoder for the data-memory responder.
package dmem_pkg;

    localparam logic [7:0]  RAM_PREFIX     = 8'h10;
    localparam logic [31:0] SW_ADDR        = 32'hF010_0000;
    localparam logic [31:0] LED_ADDR       = 32'hF020_0000;
    localparam logic [31:0] TMR_ADDR       = 32'hF060_0000;
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

    // Byte-lane bits are dropped before comparing against the I/O word addresses.
    localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_SW,
        REGION_LED,
        REGION_TMR,
        REGION_NONE
    } region_t;

    // Classifies a byte address into the region that owns it.
    function automatic region_t decode_region(input logic [31:0] addr);
        logic [31:0] word_addr;
        word_addr = addr & WORD_MASK;
        if (addr[31:24] == RAM_PREFIX) begin
            return REGION_RAM;
        end else if (word_addr == SW_ADDR) begin
            return REGION_SW;
        end else if (word_addr == LED_ADDR) begin
            return REGION_LED;
        end else if (word_addr == TMR_ADDR) begin
            return REGION_TMR;
        end else begin
            return REGION_NONE;
        end
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running 32-bit cycle counter whose value can be overwritten by the CPU.
module dmem_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] count
);

    // A load replaces the increment for that cycle; the counter wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'h0000_0000;
        end else if (load) begin
            count <= load_value;
        end else begin
            count <= count + 32'h0000_0001;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: data RAM plus LED, switch and timer registers, with a
// sticky flag for accesses that fall outside every mapped region.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data,
    input  logic        dmem_drw,
    output logic [31:0] dmem_in,
    input  logic [7:0]  switches,
    output logic [7:0]  leds,
    output logic        bus_err
);

    region_t             region;
    logic [RAM_AW-1:0]   ram_idx;
    logic                ram_we;
    logic                led_we;
    logic                tmr_we;
    logic [31:0]         tmr_count;
    logic [7:0]          sw_meta;
    logic [7:0]          sw_sync;
    logic [31:0]         ram [0:(1 << RAM_AW) - 1];

    assign region  = decode_region(dmem_addr);
    assign ram_idx = dmem_addr[RAM_AW+1:2];
    assign ram_we  = dmem_drw && (region == REGION_RAM);
    assign led_we  = dmem_drw && (region == REGION_LED);
    assign tmr_we  = dmem_drw && (region == REGION_TMR);

    // RAM is deliberately outside reset so a write coinciding with reset still lands.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= dmem_data;
        end
    end

    // LED register keeps only the low byte of the written word.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= 8'h00;
        end else if (led_we) begin
            leds <= dmem_data[7:0];
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= 8'h00;
            sw_sync <= 8'h00;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
        end
    end

    // Any cycle addressing an unmapped location latches the error until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (region == REGION_NONE) begin
            bus_err <= 1'b1;
        end
    end

    dmem_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_we),
        .load_value (dmem_data),
        .count      (tmr_count)
    );

    // Read mux reflects state before this cycle's edge so the memory stage can register it.
    always_comb begin
        dmem_in = UNMAPPED_RDATA;
        case (region)
            REGION_RAM:  dmem_in = ram[ram_idx];
            REGION_SW:   dmem_in = {24'h000000, sw_sync};
            REGION_LED:  dmem_in = {24'h000000, leds};
            REGION_TMR:  dmem_in = tmr_count;
            default:     dmem_in = UNMAPPED_RDATA;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by random
// traffic, both compared against a behavioural model of the memory map.
module tb_dmem_responder;

    localparam int RAM_AW = 10;
    localparam logic [31:0] SW_A  = 32'hF010_0000;
    localparam logic [31:0] LED_A = 32'hF020_0000;
    localparam logic [31:0] TMR_A = 32'hF060_0000;

    logic        clk;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data;
    logic        dmem_drw;
    logic [31:0] dmem_in;
    logic [7:0]  switches;
    logic [7:0]  leds;
    logic        bus_err;

    int checks;
    int errors;

    // Behavioural model state
    logic [31:0] ramModel [int];
    logic [7:0]  ledsModel;
    logic        berrModel;
    logic [7:0]  swHist [$];
    logic [31:0] edgeCnt;
    logic [31:0] tmrOrigin;
    logic [31:0] tmrEdge;

    dmem_responder #(.RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_addr (dmem_addr),
        .dmem_data (dmem_data),
        .dmem_drw  (dmem_drw),
        .dmem_in   (dmem_in),
        .switches  (switches),
        .leds      (leds),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // 0 = RAM, 1 = switches, 2 = LEDs, 3 = timer, 4 = unmapped
    function automatic int regionOf(input logic [31:0] a);
        if ((a >> 24) == 32'h10) return 0;
        if ((a >> 2) == (SW_A >> 2)) return 1;
        if ((a >> 2) == (LED_A >> 2)) return 2;
        if ((a >> 2) == (TMR_A >> 2)) return 3;
        return 4;
    endfunction

    function automatic int ramKey(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << RAM_AW));
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] a, output bit known);
        known = 1'b1;
        case (regionOf(a))
            0: begin
                if (ramModel.exists(ramKey(a))) return ramModel[ramKey(a)];
                known = 1'b0;
                return 32'h0;
            end
            1: return {24'h0, swHist[0]};
            2: return {24'h0, ledsModel};
            3: return tmrOrigin + (edgeCnt - tmrEdge);
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        ledsModel = 8'h00;
        berrModel = 1'b0;
        swHist    = '{8'h00, 8'h00};
        tmrOrigin = 32'h0;
        tmrEdge   = edgeCnt;
    endtask

    // Drive one cycle of inputs and compare the pre-edge outputs with the model.
    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic [7:0] s);
        logic [31:0] expected;
        bit known;
        rst       = r;
        dmem_addr = a;
        dmem_data = d;
        dmem_drw  = w;
        switches  = s;
        #1;
        expected = expRead(a, known);
        if (known) checkOutput("model_rdata", dmem_in, expected);
        checkOutput("model_leds", {24'h0, leds}, {24'h0, ledsModel});
        checkOutput("model_bus_err", {31'h0, bus_err}, {31'h0, berrModel});
    endtask

    // Advance through the rising edge, updating the model with the sampled inputs.
    task automatic tick();
        int reg_n;
        @(posedge clk);
        reg_n = regionOf(dmem_addr);
        edgeCnt = edgeCnt + 32'd1;
        if (dmem_drw && reg_n == 0) ramModel[ramKey(dmem_addr)] = dmem_data;
        if (rst) begin
            modelReset();
        end else begin
            if (dmem_drw && reg_n == 2) ledsModel = dmem_data[7:0];
            if (dmem_drw && reg_n == 3) begin
                tmrOrigin = dmem_data;
                tmrEdge   = edgeCnt;
            end
            swHist.push_back(switches);
            void'(swHist.pop_front());
            if (reg_n == 4) berrModel = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] tmrExp [3];
        int sel;
        checks    = 0;
        errors    = 0;
        edgeCnt   = 32'h0;
        clk       = 1'b0;
        rst       = 1'b1;
        dmem_addr = TMR_A;
        dmem_data = 32'h0;
        dmem_drw  = 1'b0;
        switches  = 8'h00;
        repeat (2) @(posedge clk);
        modelReset();
        @(negedge clk);

        // Reset state: I/O reads return reset values while rst is held
        applyStimulus(1'b1, TMR_A, 32'h0, 1'b0, 8'h00);
        checkOutput("reset_timer", dmem_in, 32'h0);
        checkOutput("reset_leds", {24'h0, leds}, 32'h0);
        checkOutput("reset_bus_err", {31'h0, bus_err}, 32'h0);
        tick();

        // Timer counts up from zero after reset
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, TMR_A, 32'h0, 1'b0, 8'h00);
            checkOutput($sformatf("timer_count_%0d", i), dmem_in, 32'(i));
            tick();
        end
        applyStimulus(1'b0, LED_A, 32'h0, 1'b0, 8'h00);
        checkOutput("led_reset_read", dmem_in, 32'h0);
        tick();

        // RAM write, read-during-write, read-after-write and aliasing
        applyStimulus(1'b0, 32'h1000_0004, 32'h1111_1111, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, 32'h1000_0004, 32'hCAFE_BABE, 1'b1, 8'h00);
        checkOutput("ram_write_cycle_old", dmem_in, 32'h1111_1111);
        tick();
        applyStimulus(1'b0, 32'h1000_0004, 32'h0, 1'b0, 8'h00);
        checkOutput("ram_read_after_write", dmem_in, 32'hCAFE_BABE);
        tick();
        applyStimulus(1'b0, 32'h1000_0000 + (32'd4 << RAM_AW) + 32'd4, 32'h0, 1'b0, 8'h00);
        checkOutput("ram_alias", dmem_in, 32'hCAFE_BABE);
        tick();

        // LED write keeps the low byte; switch writes are ignored without error
        applyStimulus(1'b0, LED_A, 32'h1234_56A5, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, LED_A, 32'h0, 1'b0, 8'h00);
        checkOutput("led_value", {24'h0, leds}, 32'h0000_00A5);
        checkOutput("led_read", dmem_in, 32'h0000_00A5);
        tick();
        applyStimulus(1'b0, SW_A, 32'hFFFF_FFFF, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, SW_A, 32'h0, 1'b0, 8'h00);
        checkOutput("sw_write_ignored", dmem_in, 32'h0);
        checkOutput("sw_write_no_err", {31'h0, bus_err}, 32'h0);
        tick();

        // Timer load and wrap
        applyStimulus(1'b0, TMR_A, 32'hFFFF_FFFE, 1'b1, 8'h00);
        tick();
        tmrExp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, TMR_A, 32'h0, 1'b0, 8'h00);
            checkOutput($sformatf("timer_wrap_%0d", i), dmem_in, tmrExp[i]);
            tick();
        end

        // Switch change takes two edges to appear
        applyStimulus(1'b0, SW_A, 32'h0, 1'b0, 8'h3C);
        checkOutput("sw_change_cycle", dmem_in, 32'h0);
        tick();
        applyStimulus(1'b0, SW_A, 32'h0, 1'b0, 8'h3C);
        checkOutput("sw_first_edge", dmem_in, 32'h0);
        tick();
        applyStimulus(1'b0, SW_A, 32'h0, 1'b0, 8'h3C);
        checkOutput("sw_second_edge", dmem_in, 32'h0000_003C);
        tick();

        // Unmapped read sets a sticky error
        applyStimulus(1'b0, 32'h2000_0000, 32'h0, 1'b0, 8'h3C);
        checkOutput("unmapped_read", dmem_in, 32'h0);
        checkOutput("bus_err_before", {31'h0, bus_err}, 32'h0);
        tick();
        applyStimulus(1'b0, LED_A, 32'h0, 1'b0, 8'h3C);
        checkOutput("bus_err_set", {31'h0, bus_err}, 32'h1);
        tick();
        applyStimulus(1'b0, TMR_A, 32'h0, 1'b0, 8'h3C);
        checkOutput("bus_err_sticky", {31'h0, bus_err}, 32'h1);
        tick();

        // Reset beats I/O writes but a coincident RAM write still lands
        applyStimulus(1'b1, LED_A, 32'h0000_00FF, 1'b1, 8'h3C);
        tick();
        applyStimulus(1'b1, 32'h1000_0008, 32'h5555_AAAA, 1'b1, 8'h3C);
        tick();
        applyStimulus(1'b0, LED_A, 32'h0, 1'b0, 8'h3C);
        checkOutput("rst_leds", {24'h0, leds}, 32'h0);
        checkOutput("rst_bus_err", {31'h0, bus_err}, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h1000_0004, 32'h0, 1'b0, 8'h3C);
        checkOutput("ram_survives_rst", dmem_in, 32'hCAFE_BABE);
        tick();
        applyStimulus(1'b0, 32'h1000_0008, 32'h0, 1'b0, 8'h3C);
        checkOutput("ram_write_in_rst", dmem_in, 32'h5555_AAAA);
        tick();

        // Random traffic across all regions against the model
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                a = 32'h1000_0000 | ($urandom & 32'h00FF_F000) |
                    (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
            end else if (sel == 5) begin
                a = SW_A | ($urandom & 32'h3);
            end else if (sel == 6) begin
                a = LED_A | ($urandom & 32'h3);
            end else if (sel == 7 || sel == 9) begin
                a = TMR_A | ($urandom & 32'h3);
            end else begin
                a = $urandom;
                if (regionOf(a) != 4) a = 32'h2000_0000;
            end
            applyStimulus(($urandom_range(0, 29) == 0), a, $urandom,
                          ($urandom_range(0, 2) == 0), 8'($urandom));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
